// File: rtl/shift_seq_pkg.sv
// Purpose : shared types for the shift sequencer (op codes, RegDesloc commands, FSM states).
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   shift_op_e    - requested operation from the main control unit
//   shifter_cmd_e - command encoding understood by RegDesloc
//   state_e       - sequencer FSM state encoding
//   op_dec_t      - decoded view of a request (command, amount source, legality)
package shift_seq_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int NW_DEFAULT    = 5;

  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_SLLV = 3'b011,
    OP_SRLV = 3'b100,
    OP_SRAV = 3'b101,
    OP_ROR  = 3'b110,
    OP_ROL  = 3'b111
  } shift_op_e;

  typedef enum logic [2:0] {
    CMD_HOLD    = 3'b000,
    CMD_LOAD    = 3'b001,
    CMD_LEFT    = 3'b010,
    CMD_RIGHT_L = 3'b011,
    CMD_RIGHT_A = 3'b100,
    CMD_ROT_R   = 3'b101,
    CMD_ROT_L   = 3'b110
  } shifter_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_LOAD    = 3'b001,
    ST_SHIFT   = 3'b010,
    ST_CAPTURE = 3'b011,
    ST_DONE    = 3'b100
  } state_e;

  typedef struct packed {
    shifter_cmd_e cmd;          // command to issue in the SHIFT phase
    logic         is_variable;  // amount comes from rs_value instead of shamt
    logic         is_illegal;   // op not supported in this build
  } op_dec_t;

endpackage

// File: rtl/shift_op_decode.sv
// Purpose : maps a shift op code to the RegDesloc command, amount source and legality.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of op.
//
// Ports:
//   op  in  3  requested shift operation (shift_op_e encoding)
//   dec out    decoded {cmd, is_variable, is_illegal}
//
// Build option SHIFT_SEQ_ROTATE_EN: when defined, ops 110/111 decode to
// rotate right/left (amount from shamt); otherwise they are illegal.
module shift_op_decode
  import shift_seq_pkg::*;
(
  input  logic [2:0] op,
  output op_dec_t    dec
);

  always_comb begin
    dec.cmd         = CMD_HOLD;
    dec.is_variable = 1'b0;
    dec.is_illegal  = 1'b0;
    case (op)
      OP_SLL:  dec.cmd = CMD_LEFT;
      OP_SRL:  dec.cmd = CMD_RIGHT_L;
      OP_SRA:  dec.cmd = CMD_RIGHT_A;
      OP_SLLV: begin
        dec.cmd         = CMD_LEFT;
        dec.is_variable = 1'b1;
      end
      OP_SRLV: begin
        dec.cmd         = CMD_RIGHT_L;
        dec.is_variable = 1'b1;
      end
      OP_SRAV: begin
        dec.cmd         = CMD_RIGHT_A;
        dec.is_variable = 1'b1;
      end
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:  dec.cmd = CMD_ROT_R;
      OP_ROL:  dec.cmd = CMD_ROT_L;
`else
      OP_ROR:  dec.is_illegal = 1'b1;
      OP_ROL:  dec.is_illegal = 1'b1;
`endif
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Purpose : multicycle initiator for RegDesloc: LOAD -> SHIFT -> CAPTURE, registered result.
// Latency : start sampled at edge k -> done pulses in the cycle after edge k+4; one request per 5 cycles.
// Backpressure: start is only honoured in IDLE; requests arriving while busy are dropped, not queued.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   start, shift_op, shamt,    request strobe and its arguments (sampled at accept only)
//   rs_value, operand
//   shifter_out                current RegDesloc contents
//   shifter_ctrl/n/din         RegDesloc command, amount and load data
//   busy, done, illegal        status; done/illegal are one-cycle pulses
//   result                     captured shift result, held until the next capture
//
// Build option SHIFT_SEQ_ROTATE_EN enables rotate ops 110/111 (see shift_op_decode).
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       shift_op,
  input  logic [NW-1:0]    shamt,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] shifter_out,
  output logic [2:0]       shifter_ctrl,
  output logic [NW-1:0]    shifter_n,
  output logic [WIDTH-1:0] shifter_din,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result
);

  // Decode the incoming op so the amount source and command are fixed at accept.
  op_dec_t in_dec;

  shift_op_decode u_decode (
    .op  (shift_op),
    .dec (in_dec)
  );

  // Only the low NW bits of rs_value form a shift amount.
  logic unused_rs_hi;
  assign unused_rs_hi = ^rs_value[WIDTH-1:NW];

  // FSM state and latched request
  state_e           state_q,   state_d;
  logic [2:0]       cmd_q,     cmd_d;
  logic             bad_q,     bad_d;
  logic [NW-1:0]    amt_q,     amt_d;
  logic [WIDTH-1:0] din_q,     din_d;

  // Registered outputs
  logic [2:0]       ctrl_q,    ctrl_d;
  logic [NW-1:0]    n_q,       n_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] result_q,  result_d;

  // Next state and request latch
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    bad_d   = bad_q;
    amt_d   = amt_q;
    din_d   = din_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cmd_d   = in_dec.cmd;
          bad_d   = in_dec.is_illegal;
          amt_d   = in_dec.is_variable ? rs_value[NW-1:0] : shamt;
          din_d   = operand;
        end
      end
      ST_LOAD:    state_d = ST_SHIFT;
      ST_SHIFT:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are the decode of the current state, registered, so the pins
  // present each phase one cycle after the FSM enters it. The CAPTURE phase
  // is therefore on the pins while state_q is DONE, and its closing edge is
  // the one that loads result and raises done together.
  always_comb begin
    ctrl_d    = CMD_HOLD;
    n_d       = '0;
    busy_d    = (state_q != ST_IDLE);
    done_d    = (state_q == ST_DONE);
    illegal_d = (state_q == ST_DONE) && bad_q;
    result_d  = result_q;
    case (state_q)
      ST_LOAD:  ctrl_d = CMD_LOAD;
      ST_SHIFT: begin
        // An illegal op leaves the loaded operand untouched.
        ctrl_d = bad_q ? CMD_HOLD : cmd_q;
        n_d    = amt_q;
      end
      ST_DONE:  result_d = shifter_out;
      default:  ctrl_d = CMD_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_HOLD;
      bad_q     <= 1'b0;
      amt_q     <= '0;
      din_q     <= '0;
      ctrl_q    <= CMD_HOLD;
      n_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      bad_q     <= bad_d;
      amt_q     <= amt_d;
      din_q     <= din_d;
      ctrl_q    <= ctrl_d;
      n_q       <= n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
    end
  end

  assign shifter_ctrl = ctrl_q;
  assign shifter_n    = n_q;
  assign shifter_din  = din_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign illegal      = illegal_q;
  assign result       = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Purpose : self-checking bench for shift_sequencer with a behavioural RegDesloc attached.
// Latency : checks the 5-cycle sequence and done in the cycle after accept edge + 4.
// Backpressure: checks that start is ignored while busy and re-sampled only in IDLE.
module tb_shift_sequencer;

  localparam int W = 32;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   shift_op = '0;
  logic [N-1:0] shamt = '0;
  logic [W-1:0] rs_value = '0;
  logic [W-1:0] operand = '0;
  logic [W-1:0] shifter_out;
  logic [2:0]   shifter_ctrl;
  logic [N-1:0] shifter_n;
  logic [W-1:0] shifter_din;
  logic         busy, done, illegal;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(W), .NW(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .shift_op     (shift_op),
    .shamt        (shamt),
    .rs_value     (rs_value),
    .operand      (operand),
    .shifter_out  (shifter_out),
    .shifter_ctrl (shifter_ctrl),
    .shifter_n    (shifter_n),
    .shifter_din  (shifter_din),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .result       (result)
  );

  // Behavioural RegDesloc
  logic [W-1:0] sr = '0;
  assign shifter_out = sr;
  always @(posedge clk) begin
    case (shifter_ctrl)
      3'b001: sr <= shifter_din;
      3'b010: sr <= sr << shifter_n;
      3'b011: sr <= sr >> shifter_n;
      3'b100: sr <= W'($signed(sr) >>> shifter_n);
      3'b101: sr <= (sr >> shifter_n) | (sr << (6'd32 - {1'b0, shifter_n}));
      3'b110: sr <= (sr << shifter_n) | (sr >> (6'd32 - {1'b0, shifter_n}));
      default: sr <= sr;
    endcase
  end

  // Trace of one request: index j is sampled at the negedge after accept edge k+j.
  logic [2:0]   ctrl_tr [6];
  logic [N-1:0] n_tr    [6];
  logic         busy_tr [6];
  logic         done_tr [6];
  logic         ill_tr  [6];
  logic [W-1:0] din_tr  [6];
  logic [W-1:0] res_tr  [6];

  task automatic issue(input logic [2:0] op, input logic [W-1:0] opd,
                       input logic [N-1:0] sa, input logic [W-1:0] rs);
    @(negedge clk);
    start = 1'b1; shift_op = op; operand = opd; shamt = sa; rs_value = rs;
    @(posedge clk);
    #1;
    // Scramble everything after accept: only latched values may matter.
    start = 1'b0; shift_op = ~op; operand = ~opd; shamt = ~sa; rs_value = ~rs;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      ctrl_tr[j] = shifter_ctrl; n_tr[j] = shifter_n; busy_tr[j] = busy;
      done_tr[j] = done; ill_tr[j] = illegal; din_tr[j] = shifter_din;
      res_tr[j] = result;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({shifter_ctrl, shifter_n, busy, done, illegal} !== 11'd0 ||
        shifter_din !== 32'd0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctrl=%b n=%0d busy=%b done=%b ill=%b din=%h res=%h, required all zero",
               shifter_ctrl, shifter_n, busy, done, illegal, shifter_din, result);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || shifter_ctrl !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b ctrl=%b, required 0 / 000", busy, shifter_ctrl);
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [W-1:0] opd;
    logic [N-1:0] sa;
    logic [W-1:0] rs;
    logic [2:0] cmd;
    logic [N-1:0] n;
    logic [W-1:0] res;
    logic       ill;
  } vec_t;

  task automatic test_single_ops();
    vec_t v [7];
    logic [2:0] exp_ctrl;
    logic       exp_busy, exp_done, exp_ill;
    v[0] = '{"sll",       3'b000, 32'h0000_0001, 5'd4, 32'h0,         3'b010, 5'd4, 32'h0000_0010, 1'b0};
    v[1] = '{"srav_33",   3'b101, 32'h8000_0000, 5'd7, 32'h0000_0021, 3'b100, 5'd1, 32'hC000_0000, 1'b0};
    v[2] = '{"srl_zero",  3'b001, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 3'b011, 5'd0, 32'hFFFF_FFFF, 1'b0};
    v[3] = '{"sllv_33",   3'b011, 32'h0000_0003, 5'd9, 32'h0000_0021, 3'b010, 5'd1, 32'h0000_0006, 1'b0};
    v[4] = '{"sra",       3'b010, 32'hF000_0000, 5'd4, 32'h0000_0002, 3'b100, 5'd4, 32'hFF00_0000, 1'b0};
`ifdef SHIFT_SEQ_ROTATE_EN
    v[5] = '{"op110_ror", 3'b110, 32'h0000_0001, 5'd1, 32'h0000_0003, 3'b101, 5'd1, 32'h8000_0000, 1'b0};
    v[6] = '{"op111_rol", 3'b111, 32'h8000_0001, 5'd1, 32'h0000_0003, 3'b110, 5'd1, 32'h0000_0003, 1'b0};
`else
    v[5] = '{"op110_ill", 3'b110, 32'h0000_0001, 5'd1, 32'h0000_0003, 3'b000, 5'd1, 32'h0000_0001, 1'b1};
    v[6] = '{"op111_ill", 3'b111, 32'h8000_0001, 5'd1, 32'h0000_0003, 3'b000, 5'd1, 32'h8000_0001, 1'b1};
`endif
    for (int i = 0; i < 7; i++) begin
      issue(v[i].op, v[i].opd, v[i].sa, v[i].rs);
      for (int j = 0; j < 6; j++) begin
        exp_ctrl = (j == 1) ? 3'b001 : (j == 2) ? v[i].cmd : 3'b000;
        exp_busy = (j >= 1 && j <= 4);
        exp_done = (j == 4);
        exp_ill  = (j == 4) && v[i].ill;
        n_checks++;
        if (ctrl_tr[j] !== exp_ctrl || busy_tr[j] !== exp_busy ||
            done_tr[j] !== exp_done || ill_tr[j] !== exp_ill) begin
          n_fail++;
          $display("FAIL %s_seq[%0d]: ctrl=%b busy=%b done=%b ill=%b, required ctrl=%b busy=%b done=%b ill=%b",
                   v[i].name, j, ctrl_tr[j], busy_tr[j], done_tr[j], ill_tr[j],
                   exp_ctrl, exp_busy, exp_done, exp_ill);
        end
        n_checks++;
        if (din_tr[j] !== v[i].opd) begin
          n_fail++;
          $display("FAIL %s_din[%0d]: got %h, required %h", v[i].name, j, din_tr[j], v[i].opd);
        end
      end
      n_checks++;
      if (n_tr[1] !== 5'd0 || n_tr[2] !== v[i].n) begin
        n_fail++;
        $display("FAIL %s_amount: load n=%0d shift n=%0d, required 0 / %0d",
                 v[i].name, n_tr[1], n_tr[2], v[i].n);
      end
      n_checks++;
      if (res_tr[4] !== v[i].res || res_tr[5] !== v[i].res) begin
        n_fail++;
        $display("FAIL %s_result: at done %h after %h, required %h",
                 v[i].name, res_tr[4], res_tr[5], v[i].res);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] c [15];
    logic       b [15];
    logic       d [15];
    int loads, first_load, second_load, busy_low;
    loads = 0; first_load = -1; second_load = -1; busy_low = 0;
    @(negedge clk);
    start = 1'b1; shift_op = 3'b000; operand = 32'h0000_0001; shamt = 5'd1; rs_value = '0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) start = 1'b0;
      @(negedge clk);
      c[i] = shifter_ctrl; b[i] = busy; d[i] = done;
    end
    for (int i = 0; i < 15; i++) begin
      if (c[i] == 3'b001) begin
        loads++;
        if (first_load < 0) first_load = i; else second_load = i;
      end
      if (i >= 1 && i <= 9 && b[i] == 1'b0) busy_low++;
      n_checks++;
      if (d[i] !== ((i == 4) || (i == 9))) begin
        n_fail++;
        $display("FAIL b2b_done[%0d]: got %b, required %b", i, d[i], (i == 4) || (i == 9));
      end
    end
    n_checks++;
    if (loads != 2 || first_load != 1 || second_load != 6) begin
      n_fail++;
      $display("FAIL b2b_accepts: %0d loads at %0d and %0d, required 2 loads at 1 and 6",
               loads, first_load, second_load);
    end
    n_checks++;
    if (busy_low != 1 || b[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy_gap: %0d low cycles (busy at gap=%b), required exactly 1 at index 5",
               busy_low, b[5]);
    end
    n_checks++;
    if (result !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL b2b_result: got %h, required 00000002", result);
    end
  endtask

  task automatic test_reset_mid_shift();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    start = 1'b1; shift_op = 3'b000; operand = 32'h0000_00F0; shamt = 5'd3; rs_value = '0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (shifter_ctrl !== 3'b010 || shifter_n !== 5'd3) begin
      n_fail++;
      $display("FAIL abort_pre_shift: ctrl=%b n=%0d, required 010 / 3", shifter_ctrl, shifter_n);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({shifter_ctrl, shifter_n, busy, done, illegal} !== 11'd0 ||
        shifter_din !== 32'd0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: ctrl=%b n=%0d busy=%b done=%b ill=%b din=%h res=%h, required all zero",
               shifter_ctrl, shifter_n, busy, done, illegal, shifter_din, result);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_after: %0d cycles with done/busy, result=%h, required 0 / 00000000",
               done_seen, result);
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
